// File: rtl/gray_counter_nbit_step.sv
// N-bit Gray/binary counter advanced by an upstream 1 Hz tick, with run/stop FSM,
// manual single-step while stopped, and synchronous parallel load.
module gray_counter_nbit_step #(
    parameter int N             = 4,
    parameter bit RESET_RUNNING = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         pulse,
    input  logic         up_down,
    input  logic         start,
    input  logic         stop,
    input  logic         step,
    input  logic         load,
    input  logic [N-1:0] load_value,
    output logic [N-1:0] gray_out,
    output logic [N-1:0] bin_out,
    output logic         wrap,
    output logic         running
);

    typedef enum logic {
        ST_STOPPED = 1'b0,
        ST_RUNNING = 1'b1
    } state_t;

    localparam state_t RESET_STATE = RESET_RUNNING ? ST_RUNNING : ST_STOPPED;

    state_t       state_q, state_d;
    logic [N-1:0] bin_q, bin_d;
    logic [N-1:0] gray_q, gray_d;
    logic         wrap_q, wrap_d;
    logic         running_q, running_d;
    logic         step_q;
    logic         step_edge;
    logic         adv;

    assign step_edge = step & ~step_q;
    // Advance source is chosen by the state before this edge, so a stop
    // arriving together with a pulse still lets that pulse count.
    assign adv = (state_q == ST_RUNNING) ? pulse : step_edge;

    always_comb begin
        state_d = state_q;
        if (stop) begin
            state_d = ST_STOPPED;
        end else if (start) begin
            state_d = ST_RUNNING;
        end
        running_d = (state_d == ST_RUNNING);
    end

    always_comb begin
        bin_d  = bin_q;
        wrap_d = 1'b0;
        if (load) begin
            bin_d = load_value;
        end else if (adv) begin
            if (up_down) begin
                bin_d  = bin_q + N'(1);
                wrap_d = &bin_q;
            end else begin
                bin_d  = bin_q - N'(1);
                wrap_d = ~|bin_q;
            end
        end
        // Gray is derived from the next binary value so both views flip together.
        gray_d = bin_d ^ (bin_d >> 1);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= RESET_STATE;
            running_q <= RESET_RUNNING;
            bin_q     <= '0;
            gray_q    <= '0;
            wrap_q    <= 1'b0;
            step_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= running_d;
            bin_q     <= bin_d;
            gray_q    <= gray_d;
            wrap_q    <= wrap_d;
            step_q    <= step;
        end
    end

    assign bin_out  = bin_q;
    assign gray_out = gray_q;
    assign wrap     = wrap_q;
    assign running  = running_q;

endmodule

// File: tb/tb_gray_counter_nbit_step.sv
// Directed plus randomized check of gray_counter_nbit_step against an
// arithmetic reference model of the count, wrap and run/stop behaviour.
module tb_gray_counter_nbit_step;

    localparam int N   = 4;
    localparam int MOD = 1 << N;
    localparam bit RR  = 1'b1;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         pulse = 1'b0, up_down = 1'b1, start = 1'b0, stop = 1'b0;
    logic         step = 1'b0, load = 1'b0;
    logic [N-1:0] load_value = '0;
    logic [N-1:0] gray_out, bin_out;
    logic         wrap, running;

    gray_counter_nbit_step #(.N(N), .RESET_RUNNING(RR)) dut (
        .clk(clk), .reset(reset), .pulse(pulse), .up_down(up_down),
        .start(start), .stop(stop), .step(step), .load(load),
        .load_value(load_value), .gray_out(gray_out), .bin_out(bin_out),
        .wrap(wrap), .running(running)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    int m_cnt;
    bit m_wrap, m_run, m_stepq;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int to_gray(input int b);
        return b ^ (b >> 1);
    endfunction

    task automatic m_reset();
        m_cnt = 0; m_wrap = 0; m_run = RR; m_stepq = 0;
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_bin"},  32'(bin_out),  32'(m_cnt));
        chk({tag, "_gray"}, 32'(gray_out), 32'(to_gray(m_cnt)));
        chk({tag, "_wrap"}, 32'(wrap),     32'(m_wrap));
        chk({tag, "_run"},  32'(running),  32'(m_run));
    endtask

    // One clock: predict from the inputs held across the edge, then compare.
    task automatic cyc(input string tag);
        int  n_cnt;
        bit  n_wrap, n_run, adv;
        adv    = m_run ? pulse : (step && !m_stepq);
        n_cnt  = m_cnt;
        n_wrap = 0;
        if (load) begin
            n_cnt = int'(load_value);
        end else if (adv) begin
            if (up_down) begin
                n_wrap = (m_cnt + 1 == MOD);
                n_cnt  = (m_cnt + 1) % MOD;
            end else begin
                n_wrap = (m_cnt == 0);
                n_cnt  = (m_cnt + MOD - 1) % MOD;
            end
        end
        n_run = stop ? 1'b0 : (start ? 1'b1 : m_run);
        @(posedge clk);
        #1;
        m_cnt = n_cnt; m_wrap = n_wrap; m_run = n_run; m_stepq = step;
        check_all(tag);
    endtask

    task automatic pulse_spaced(input string tag);
        pulse = 1'b1; cyc(tag); pulse = 1'b0;
        repeat (4) cyc(tag);
    endtask

    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1 m_reset();
        check_all(tag);
        #2 reset = 1'b0;
    endtask

    initial begin
        logic [3:0] gseq [0:16];
        int base;
        gseq = '{4'h0, 4'h1, 4'h3, 4'h2, 4'h6, 4'h7, 4'h5, 4'h4, 4'hC,
                 4'hD, 4'hF, 4'hE, 4'hA, 4'hB, 4'h9, 4'h8, 4'h0};
        m_reset();
        #12;
        check_all("reset");
        #1 reset = 1'b0;

        // Full up-count cycle with spaced pulses
        up_down = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pulse = 1'b1; cyc("up");
            chk("up_seq", 32'(gray_out), 32'(gseq[i+1]));
            chk("up_wrap", 32'(wrap), (i == 15) ? 32'd1 : 32'd0);
            pulse = 1'b0;
            repeat (4) cyc("up_gap");
        end

        // Down count from zero wraps to all ones
        async_reset("rst2");
        up_down = 1'b0;
        pulse = 1'b1; cyc("dn1"); pulse = 1'b0;
        chk("dn1_bin", 32'(bin_out), 32'hF);
        chk("dn1_gray", 32'(gray_out), 32'h8);
        chk("dn1_wrap", 32'(wrap), 32'd1);
        repeat (4) cyc("dn_gap");
        pulse = 1'b1; cyc("dn2"); pulse = 1'b0;
        chk("dn2_bin", 32'(bin_out), 32'hE);
        chk("dn2_gray", 32'(gray_out), 32'h9);
        chk("dn2_wrap", 32'(wrap), 32'd0);

        // Load beats a simultaneous pulse
        up_down = 1'b1;
        load = 1'b1; load_value = 4'hA; pulse = 1'b1; cyc("load");
        load = 1'b0; pulse = 1'b0;
        chk("load_bin", 32'(bin_out), 32'hA);
        chk("load_gray", 32'(gray_out), 32'hF);
        chk("load_wrap", 32'(wrap), 32'd0);

        // Stopped: pulses ignored, step edges counted once each
        stop = 1'b1; cyc("stop"); stop = 1'b0;
        chk("stop_run", 32'(running), 32'd0);
        repeat (3) pulse_spaced("stop_pulse");
        chk("stop_hold", 32'(bin_out), 32'hA);
        base = int'(bin_out);
        step = 1'b1; repeat (10) cyc("step_hi");
        step = 1'b0; repeat (3) cyc("step_lo");
        step = 1'b1; repeat (3) cyc("step_hi2");
        step = 1'b0; cyc("step_lo2");
        chk("step_two", 32'(bin_out), 32'((base + 2) % MOD));
        start = 1'b1; cyc("start"); start = 1'b0;
        chk("start_run", 32'(running), 32'd1);
        pulse_spaced("run_again");
        start = 1'b1; stop = 1'b1; cyc("both"); start = 1'b0; stop = 1'b0;
        chk("both_run", 32'(running), 32'd0);

        // Stop coinciding with a pulse still counts that pulse
        start = 1'b1; cyc("restart"); start = 1'b0;
        base = int'(bin_out);
        stop = 1'b1; pulse = 1'b1; cyc("stop_pulse_same");
        stop = 1'b0; pulse = 1'b0;
        chk("stop_same_cnt", 32'(bin_out), 32'((base + 1) % MOD));
        repeat (2) pulse_spaced("after_stop");
        chk("after_stop_cnt", 32'(bin_out), 32'((base + 1) % MOD));

        // Asynchronous reset mid-count at 7
        load = 1'b1; load_value = 4'h7; cyc("ld7"); load = 1'b0;
        chk("ld7_bin", 32'(bin_out), 32'h7);
        async_reset("rst_mid");
        chk("rst_mid_bin", 32'(bin_out), 32'h0);

        // Randomized traffic, including back-to-back pulses and wraps
        for (int i = 0; i < 400; i++) begin
            pulse      = ($urandom_range(0, 2) != 0);
            up_down    = ($urandom_range(0, 3) != 0);
            step       = $urandom_range(0, 1) == 1;
            stop       = ($urandom_range(0, 15) == 0);
            start      = ($urandom_range(0, 7) == 0);
            load       = ($urandom_range(0, 19) == 0);
            load_value = N'($urandom);
            cyc("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/gray_counter_nbit_step.md
Name: gray_counter_nbit_step

Overview:
- N-bit Gray-code counter. Consumes the single-cycle 1 Hz tick from the pulse generator stage and advances once per tick.
- Supports up/down direction, run/stop control, manual single-step while stopped, and synchronous parallel load.
- Drives the board display with Gray and binary views of the count plus a one-cycle wrap flag.
- Sits directly downstream of the pulse generator, sharing its clock and reset.

Parameters:
- N, 4, counter width in bits (legal range 2..16).
- RESET_RUNNING, 1, run/stop state entered on reset (1 = RUNNING, 0 = STOPPED).

Ports:
- clk  input  1  system clock; all flops on rising edge.
- reset  input  1  asynchronous, active-high reset.
- pulse  input  1  one-cycle advance tick from the pulse generator.
- up_down  input  1  direction: 1 = increment, 0 = decrement; sampled on the advancing cycle.
- start  input  1  level; enter RUNNING (already debounced/synchronized upstream).
- stop  input  1  level; enter STOPPED.
- step  input  1  level; rising edge advances one count while STOPPED.
- load  input  1  synchronous load strobe.
- load_value  input  N  binary value to load.
- gray_out  output  N  registered Gray code of the count.
- bin_out  output  N  registered binary count.
- wrap  output  1  one-cycle flag on terminal-count rollover.
- running  output  1  1 while in RUNNING.

Behaviour:
- Reset (async, any time, including mid-operation):
  - bin_out=0, gray_out=0, wrap=0.
  - State = RUNNING if RESET_RUNNING=1, else STOPPED; running reflects the reset state.
  - step edge-detect register cleared to 0.
- Internal state: binary count register B[N-1:0]. gray_out is always the registered value of B ^ (B>>1) and updates on the same edge as B, so bin_out and gray_out never disagree in any cycle.
- FSM: two states, RUNNING and STOPPED.
  - RUNNING -> STOPPED when stop=1.
  - STOPPED -> RUNNING when start=1 and stop=0.
  - start and stop both 1: stop wins (goes to or stays in STOPPED).
  - running is registered and equals (state==RUNNING).
- Step edge detect: step_q registers step each cycle; step_edge = step & ~step_q. A step held high yields exactly one edge.
- Advance event adv:
  - adv = pulse when state==RUNNING.
  - adv = step_edge when state==STOPPED.
  - State is the value before this edge; a stop arriving in the same cycle as a pulse still lets that pulse count.
  - pulse is ignored in STOPPED; step is ignored in RUNNING.
- Priority per cycle: load > adv > hold.
  - load=1: B <= load_value, wrap <= 0; any adv in the same cycle is discarded.
  - adv=1 and up_down=1: B <= B+1 mod 2^N. wrap <= 1 iff B was 2^N-1.
  - adv=1 and up_down=0: B <= B-1 mod 2^N. wrap <= 1 iff B was 0.
  - Otherwise: B holds, wrap <= 0.
- Latency: an advance or load in cycle k is visible on bin_out/gray_out in cycle k+1. wrap is high only in cycle k+1, for exactly one cycle.
- Consecutive adv on back-to-back cycles must each count (no minimum spacing assumed).
- Load does not alter FSM state.

Test Plan:
- N=4, reset released in RUNNING, 16 pulses spaced 5 cycles apart, up_down=1 -> gray_out steps 0,1,3,2,6,7,5,4,C,D,F,E,A,B,9,8 then 0; wrap=1 for exactly one cycle on the 8->0 step; bin_out 15->0.
- From reset, up_down=0, one pulse -> bin_out=F, gray_out=8, wrap=1 for one cycle; second pulse -> bin_out=E, gray_out=9, wrap=0.
- load=1 with load_value=4'hA, asserted in the same cycle as pulse -> next cycle bin_out=A, gray_out=F, wrap=0; the pulse is not counted.
- stop=1 then 3 pulses -> count unchanged, running=0. step held high 10 cycles, then low, then high again -> exactly 2 increments. start=1 -> running=1 and pulses count again. start and stop high together -> STOPPED.
- Stop asserted in the same cycle as a pulse while RUNNING -> that pulse increments, subsequent pulses ignored.
- Reset asserted asynchronously mid-count at bin_out=7 (between clock edges) -> outputs 0 immediately without a clock edge, wrap=0, running=RESET_RUNNING.
